structural_mux41: RTL and testbench
===================================

Name: structural_mux41

Overview:
- Gate-level (structural) 4:1 multiplexer: 2-bit select `s` picks one of four data inputs `d0..d3` and drives it onto `y`.
- Built only from primitive NOT/AND/OR gates; no behavioural `?:`/`case` in the datapath.
- Also provides a registered copy `y_q` for downstream synchronous logic.
- Used as a leaf selector cell in datapath muxing trees.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs. Legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock; used by `y_q` only.
- rst_n  input  1  synchronous active-low reset.
- d0  input  WIDTH  data, selected when s=2'b00.
- d1  input  WIDTH  data, selected when s=2'b01.
- d2  input  WIDTH  data, selected when s=2'b10.
- d3  input  WIDTH  data, selected when s=2'b11.
- s  input  2  select; s[1] is the MSB.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low (clk, rst_n).
- Select decode: ns0 = ~s[0] and ns1 = ~s[1] from NOT gates. Four 2-input AND gates form one-hot terms:
  - t0 = ns1 & ns0
  - t1 = ns1 & s[0]
  - t2 = s[1] & ns0
  - t3 = s[1] & s[0]
- Per bit i: y[i] = (d0[i]&t0) | (d1[i]&t1) | (d2[i]&t2) | (d3[i]&t3), using 3-input AND and 4-input OR gates (or equivalent trees). Generate one gate slice per bit.
- Truth table:
  - s=00 -> y=d0
  - s=01 -> y=d1
  - s=10 -> y=d2
  - s=11 -> y=d3
- y is purely combinational with zero-cycle latency and does not depend on clk or rst_n. It settles within one gate-delay chain, and a new value is stable 10 ns after any input change.
- X/Z on `s` may propagate X to y; this is not checked. An X on an unselected data input must not affect y when `s` is known.
- y_q: at each rising clk edge:
  - rst_n=0 -> y_q <= {WIDTH{1'b0}}
  - otherwise -> y_q <= y (one-cycle latency)
- Reset value of y_q is all-zero. y has no reset value; it always follows its inputs, including during reset.
- Reset asserted mid-operation: y_q clears at the next rising edge. The first rising edge with rst_n=1 loads the current y.
- Inputs changing between edges: y_q captures only the value present at the edge. There is no glitch filtering.

Optional Feature:
- Macro: STRUCTURAL_MUX41_HOLD_EN.
- Defined:
  - Adds input port `en` (1 bit) after `s`.
  - At a rising edge with rst_n=1: en=1 loads y_q <= y; en=0 holds y_q.
  - Reset has priority over en.
  - y is unaffected by en.
- Undefined:
  - No `en` port.
  - y_q loads y on every non-reset rising edge.

Test Plan:
- Exhaustive combinational sweep, WIDTH=1: drive {s[1],s[0],d3,d2,d1,d0} = n for n=0..63 with 10 ns per step -> y equals bit s of {d3,d2,d1,d0}. Examples:
  - n=6 (s=00, d={0,1,1,0}) -> y=0
  - n=22 (s=01, d1=1) -> y=1
  - n=40 (s=10, d3..d0=1000) -> y=0
  - n=63 -> y=1
- Unselected isolation: s=2'b10, d2=1, toggle d0/d1/d3 through all 8 combinations -> y stays 1.
- Wide data, WIDTH=8:
  - d0=8'hA5, d1=8'h3C, d2=8'hF0, d3=8'h0F; step s 0..3 -> y = A5, 3C, F0, 0F.
  - Set d1=8'h00, d2=8'hFF -> y follows the selected input.
- Register and reset:
  - Hold rst_n=0 for 2 edges -> y_q=0 while y=d(s).
  - Release rst_n with s=11, d3=1 -> y_q=1 after the first edge.
  - Drive rst_n=0 mid-stream -> y_q=0 at the next edge, not before.
- Latency: change s from 00 to 11 between edges (d0=0, d3=1) -> y=1 immediately; y_q=1 only after the next rising edge.
- With STRUCTURAL_MUX41_HOLD_EN:
  - en=0, change s so y goes 0 -> 1 -> y_q holds 0 across 3 edges.
  - en=1 -> y_q=1 at the next edge.
  - rst_n=0 with en=0 -> y_q=0.

Source files
------------

// File: rtl/structural_mux41.sv
// Gate-level 4:1 multiplexer with a registered copy of the output.
// Optional macro STRUCTURAL_MUX41_HOLD_EN adds a load enable `en` for y_q.
module structural_mux41 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
`ifdef STRUCTURAL_MUX41_HOLD_EN
    input  logic             en,
`endif
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    wire ns0;
    wire ns1;
    wire t0;
    wire t1;
    wire t2;
    wire t3;
    wire [WIDTH-1:0] y_g;

    // One-hot select decode shared by every bit slice.
    not u_ns0 (ns0, s[0]);
    not u_ns1 (ns1, s[1]);
    and u_t0  (t0, ns1, ns0);
    and u_t1  (t1, ns1, s[0]);
    and u_t2  (t2, s[1], ns0);
    and u_t3  (t3, s[1], s[0]);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire a0;
        wire a1;
        wire a2;
        wire a3;
        and u_a0 (a0, d0[i], t0);
        and u_a1 (a1, d1[i], t1);
        and u_a2 (a2, d2[i], t2);
        and u_a3 (a3, d3[i], t3);
        or  u_or (y_g[i], a0, a1, a2, a3);
    end

    assign y = y_g;

    // Registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
`ifdef STRUCTURAL_MUX41_HOLD_EN
            if (en) begin
                y_q <= y_g;
            end
`else
            y_q <= y_g;
`endif
        end
    end

endmodule

// File: tb/tb_structural_mux41.sv
// Scoreboard bench for structural_mux41: driver pushes expectations, monitor checks y and y_q.
module tb_structural_mux41;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] d0, d1, d2, d3;
    logic [1:0]   s;
    logic         en;
    logic [W-1:0] y;
    logic [W-1:0] y_q;

    int checks;
    int failures;

    typedef struct packed {
        logic [W-1:0] ey;
        logic         pre_known;
        logic [W-1:0] qpre;
        logic [W-1:0] qpost;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] q_model;
    logic         q_known;

    structural_mux41 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .s     (s),
`ifdef STRUCTURAL_MUX41_HOLD_EN
        .en    (en),
`endif
        .y     (y),
        .y_q   (y_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one step after a falling edge and record what the reference predicts.
    task automatic step(input logic [1:0] si, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] e, input logic r,
                        input logic en_i);
        logic [W-1:0] data [4];
        exp_t x;
        @(negedge clk);
        #1;
        s = si; d0 = a; d1 = b; d2 = c; d3 = e; rst_n = r; en = en_i;
        data[0] = a; data[1] = b; data[2] = c; data[3] = e;
        x.ey        = data[si];
        x.pre_known = q_known;
        x.qpre      = q_model;
`ifdef STRUCTURAL_MUX41_HOLD_EN
        if (!r)        x.qpost = '0;
        else if (en_i) x.qpost = data[si];
        else           x.qpost = q_model;
        q_known = q_known | !r | en_i;
`else
        x.qpost = r ? data[si] : '0;
        q_known = 1'b1;
`endif
        q_model = x.qpost;
        sb.push_back(x);
    endtask

    // Monitor: y and pre-edge y_q sampled before the rising edge, y_q again just after it.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (y !== x.ey) begin
                    failures++;
                    $display("FAIL y: s=%0d got=%h expected=%h", s, y, x.ey);
                end
                if (x.pre_known) begin
                    checks++;
                    if (y_q !== x.qpre) begin
                        failures++;
                        $display("FAIL y_q_before_edge: got=%h expected=%h", y_q, x.qpre);
                    end
                end
                @(posedge clk);
                #1;
                checks++;
                if (y_q !== x.qpost) begin
                    failures++;
                    $display("FAIL y_q_after_edge: rst_n=%0b got=%h expected=%h", rst_n, y_q, x.qpost);
                end
            end
        end
    end

    initial begin
        logic [5:0] n;
        logic [W-1:0] r0, r1, r2, r3;
        int waited;
        checks = 0; failures = 0;
        q_model = '0; q_known = 1'b0;
        rst_n = 1'b0; en = 1'b1; s = 2'b00;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;

        // Reset held for two edges; y still follows the selected input.
        step(2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b1);
        step(2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b1);
        // Release with s=11, d3=1.
        step(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);

        // Exhaustive sweep on bit 0, random upper bits.
        for (int k = 0; k < 64; k++) begin
            n = 6'(k);
            r0 = {W'($urandom) >> 1, n[0]};
            r1 = {W'($urandom) >> 1, n[1]};
            r2 = {W'($urandom) >> 1, n[2]};
            r3 = {W'($urandom) >> 1, n[3]};
            step(n[5:4], r0, r1, r2, r3, 1'b1, 1'b1);
        end

        // Unselected inputs toggled while s=10 selects an all-ones d2.
        for (int k = 0; k < 8; k++) begin
            step(2'b10, {W{k[0]}}, {W{k[1]}}, 8'hFF, {W{k[2]}}, 1'b1, 1'b1);
        end

        // Wide patterns.
        for (int k = 0; k < 4; k++) step(2'(k), 8'hA5, 8'h3C, 8'hF0, 8'h0F, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(2'(k), 8'hA5, 8'h00, 8'hFF, 8'h0F, 1'b1, 1'b1);

        // Latency: s 00 -> 11 with d0=0, d3=1.
        step(2'b00, 8'h00, 8'h55, 8'hAA, 8'h01, 1'b1, 1'b1);
        step(2'b11, 8'h00, 8'h55, 8'hAA, 8'h01, 1'b1, 1'b1);
        // Reset mid-stream after a nonzero capture.
        step(2'b10, 8'h00, 8'h55, 8'hAA, 8'h01, 1'b1, 1'b1);
        step(2'b10, 8'h00, 8'h55, 8'hAA, 8'h01, 1'b0, 1'b1);
        step(2'b01, 8'h00, 8'h55, 8'hAA, 8'h01, 1'b1, 1'b1);

`ifdef STRUCTURAL_MUX41_HOLD_EN
        step(2'b00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        step(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        step(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        step(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        step(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
        step(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
`endif

        // Random traffic with occasional reset.
        for (int k = 0; k < 80; k++) begin
            step(2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                 ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0));
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
